// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the IF/DE and DE/EX pipeline registers.
// Optional forwarding build: define HAZARD_FWD_EN (default: stall-only, no forwarding).
module hazard_ctrl #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1Addr,
   input  logic [REG_AW-1:0] rs2Addr,
   input  logic              rs1Used,
   input  logic              rs2Used,
   input  logic [REG_AW-1:0] rdDe,
   input  logic              ruWriteDe,
   input  logic [1:0]        ruDataSrcDe,
   input  logic              branchTaken,
   output logic              stallIF,
   output logic              stallDE,
   output logic              flushIF,
   output logic              flushDE,
   output logic [1:0]        fwdA,
   output logic [1:0]        fwdB,
   output logic [CNT_W-1:0]  stallCount
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              is_load;
   } sb_t;

   sb_t              ex_q, mem_q, wb_q, ex_d;
   logic [1:0]       fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
   logic [CNT_W-1:0] cnt_q;
   logic             a_ex, a_mem, b_ex, b_mem, hazard;
   logic             unused_sb;

   function automatic logic src_match(input logic [REG_AW-1:0] s, input logic used,
                                      input sb_t e);
      return used && e.valid && (s != '0) && (s == e.rd);
   endfunction

   assign a_ex  = src_match(rs1Addr, rs1Used, ex_q);
   assign a_mem = src_match(rs1Addr, rs1Used, mem_q);
   assign b_ex  = src_match(rs2Addr, rs2Used, ex_q);
   assign b_mem = src_match(rs2Addr, rs2Used, mem_q);

`ifdef HAZARD_FWD_EN
   // Only load-use must wait; every other RAW hazard is covered by a forward path.
   assign hazard    = (a_ex || b_ex) && ex_q.is_load;
   assign fwd_a_d   = a_ex ? 2'b01 : (a_mem ? 2'b10 : 2'b00);
   assign fwd_b_d   = b_ex ? 2'b01 : (b_mem ? 2'b10 : 2'b00);
   assign unused_sb = ^{wb_q, mem_q.is_load};
`else
   assign hazard    = a_ex || a_mem || b_ex || b_mem;
   assign fwd_a_d   = 2'b00;
   assign fwd_b_d   = 2'b00;
   assign unused_sb = ^{wb_q, mem_q.is_load, ex_q.is_load};
`endif

   always_comb begin
      stallIF = 1'b0;
      stallDE = 1'b0;
      flushIF = 1'b0;
      flushDE = 1'b0;
      if (!rst) begin
         if (branchTaken) begin
            flushIF = 1'b1;
            flushDE = 1'b1;
         end else if (hazard) begin
            stallIF = 1'b1;
            stallDE = 1'b1;
            flushDE = 1'b1;
         end
      end
   end

   always_comb begin
      ex_d         = '0;
      ex_d.valid   = ruWriteDe && (rdDe != '0) && !flushDE;
      ex_d.rd      = rdDe;
      ex_d.is_load = (ruDataSrcDe == 2'b01);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         fwd_a_q <= 2'b00;
         fwd_b_q <= 2'b00;
         cnt_q   <= '0;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= ex_q;
         wb_q    <= mem_q;
         fwd_a_q <= flushDE ? 2'b00 : fwd_a_d;
         fwd_b_q <= flushDE ? 2'b00 : fwd_b_d;
         if (stallIF && (cnt_q != '1)) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Registered outputs are masked so every output reads zero for the whole reset window.
   assign fwdA       = rst ? 2'b00 : fwd_a_q;
   assign fwdB       = rst ? 2'b00 : fwd_b_q;
   assign stallCount = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: randomized and directed stimulus against a
// behavioural model of in-flight producers; a CNT_W=4 instance checks counter saturation.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1Addr, rs2Addr, rdDe;
   logic       rs1Used, rs2Used, ruWriteDe, branchTaken;
   logic [1:0] ruDataSrcDe;

   logic        stallIF, stallDE, flushIF, flushDE;
   logic [1:0]  fwdA, fwdB;
   logic [31:0] stallCount;
   logic        stallIF4, stallDE4, flushIF4, flushDE4;
   logic [1:0]  fwdA4, fwdB4;
   logic [3:0]  stallCount4;

   wire [7:0] ctl  = {stallIF, stallDE, flushIF, flushDE, fwdA, fwdB};
   wire [7:0] ctl4 = {stallIF4, stallDE4, flushIF4, flushDE4, fwdA4, fwdB4};

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .rst(rst), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs1Used(rs1Used),
      .rs2Used(rs2Used), .rdDe(rdDe), .ruWriteDe(ruWriteDe), .ruDataSrcDe(ruDataSrcDe),
      .branchTaken(branchTaken), .stallIF(stallIF), .stallDE(stallDE), .flushIF(flushIF),
      .flushDE(flushDE), .fwdA(fwdA), .fwdB(fwdB), .stallCount(stallCount)
   );

   hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs1Used(rs1Used),
      .rs2Used(rs2Used), .rdDe(rdDe), .ruWriteDe(ruWriteDe), .ruDataSrcDe(ruDataSrcDe),
      .branchTaken(branchTaken), .stallIF(stallIF4), .stallDE(stallDE4), .flushIF(flushIF4),
      .flushDE(flushDE4), .fwdA(fwdA4), .fwdB(fwdB4), .stallCount(stallCount4)
   );

   // Model: producers issued into DE/EX, youngest first (age 0 = one cycle ago).
   typedef struct packed {bit v; bit [4:0] rd; bit ld;} prod_t;
   prod_t    inflight[$];
   bit [1:0] m_fa, m_fb;
   int       m_stalls;
   prod_t    p_new;
   bit [1:0] p_fa, p_fb;
   bit       p_stall;
   bit       p_rst = 1'b1;
   bit [7:0] e_ctl;
   bit [31:0] e_cnt;
   bit [3:0]  e_cnt4;

   int n_checks = 0;
   int n_pass   = 0;

   function automatic bit reads(bit [4:0] s, bit used, prod_t p);
      return used && s != 5'd0 && p.v && p.rd == s;
   endfunction

   task automatic apply(input bit r, input bit [4:0] a1, input bit [4:0] a2, input bit u1,
                        input bit u2, input bit [4:0] d, input bit w, input bit [1:0] s,
                        input bit b);
      bit ae, am, be, bm, haz, br, hz;
      @(negedge clk);
      if (p_rst) begin
         inflight = {};
         repeat (3) inflight.push_back('0);
         m_fa = 2'b00;
         m_fb = 2'b00;
         m_stalls = 0;
      end else begin
         inflight.push_front(p_new);
         void'(inflight.pop_back());
         m_fa = p_fa;
         m_fb = p_fb;
         if (p_stall) m_stalls++;
      end
      rst = r; rs1Addr = a1; rs2Addr = a2; rs1Used = u1; rs2Used = u2;
      rdDe = d; ruWriteDe = w; ruDataSrcDe = s; branchTaken = b;
      #1;
      ae = reads(a1, u1, inflight[0]);
      am = reads(a1, u1, inflight[1]);
      be = reads(a2, u2, inflight[0]);
      bm = reads(a2, u2, inflight[1]);
`ifdef HAZARD_FWD_EN
      haz = (ae || be) && inflight[0].ld;
`else
      haz = ae || am || be || bm;
`endif
      br = !r && b;
      hz = !r && !b && haz;
      if (r) begin
         e_ctl = 8'h00; e_cnt = 32'd0; e_cnt4 = 4'd0;
      end else begin
         e_ctl  = {hz, hz, br, br || hz, m_fa, m_fb};
         e_cnt  = 32'(m_stalls);
         e_cnt4 = (m_stalls > 15) ? 4'd15 : 4'(m_stalls);
      end
      p_rst   = r;
      p_stall = hz;
      p_new.v  = w && d != 5'd0 && !(br || hz);
      p_new.rd = d;
      p_new.ld = (s == 2'b01);
`ifdef HAZARD_FWD_EN
      p_fa = (br || hz) ? 2'b00 : (ae ? 2'b01 : (am ? 2'b10 : 2'b00));
      p_fb = (br || hz) ? 2'b00 : (be ? 2'b01 : (bm ? 2'b10 : 2'b00));
`else
      p_fa = 2'b00;
      p_fb = 2'b00;
`endif
   endtask

   task automatic nop();
      apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
   endtask

   task automatic test_reset();
      apply(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 2'b01, 1'b0);
      // Create a load-use stall, then hit it with a 3-cycle reset.
      apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0);
      apply(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 2'b00, 1'b0);
      n_checks++;
      if (stallIF !== 1'b1) $display("FAIL reset_prestall: stallIF=%b want 1", stallIF);
      else n_pass++;
      repeat (3) begin
         apply(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 2'b00, 1'b1);
         n_checks++;
         if (ctl !== 8'h00 || stallCount !== 32'd0 || ctl4 !== 8'h00 || stallCount4 !== 4'd0)
            $display("FAIL reset_outputs: ctl=%b cnt=%0d want ctl=00000000 cnt=0", ctl,
                     stallCount);
         else n_pass++;
      end
      apply(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd8, 1'b0, 2'b00, 1'b0);
      n_checks++;
      if (stallIF !== 1'b0 || ctl !== e_ctl || stallCount !== e_cnt)
         $display("FAIL reset_no_stale: ctl=%b cnt=%0d want ctl=%b cnt=%0d", ctl, stallCount,
                  e_ctl, e_cnt);
      else n_pass++;
   endtask

   task automatic test_raw();
      int c0, st;
`ifdef HAZARD_FWD_EN
      apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 2'b00, 1'b0);
      apply(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
      n_checks++;
      if (stallIF !== 1'b0) $display("FAIL fwd_ex_nostall: stallIF=%b want 0", stallIF);
      else n_pass++;
      nop();
      n_checks++;
      if (fwdA !== 2'b01 || ctl !== e_ctl) $display("FAIL fwd_ex: fwdA=%b want 01", fwdA);
      else n_pass++;
      apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 2'b00, 1'b0);
      nop();
      apply(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
      nop();
      n_checks++;
      if (fwdA !== 2'b10 || ctl !== e_ctl) $display("FAIL fwd_mem: fwdA=%b want 10", fwdA);
      else n_pass++;
      apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 2'b01, 1'b0);
`else
      apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 2'b00, 1'b0);
`endif
      c0 = -1;
      st = 0;
      for (int i = 0; i < 5; i++) begin
`ifdef HAZARD_FWD_EN
         apply(1'b0, 5'd0, 5'd6, 1'b0, 1'b1, 5'd0, 1'b0, 2'b00, 1'b0);
`else
         apply(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
`endif
         if (c0 < 0) c0 = int'(stallCount);
         n_checks++;
         if (ctl !== e_ctl || stallCount !== e_cnt)
            $display("FAIL raw_model: ctl=%b cnt=%0d want ctl=%b cnt=%0d", ctl, stallCount,
                     e_ctl, e_cnt);
         else n_pass++;
         if (stallIF !== 1'b1) break;
         st++;
      end
`ifdef HAZARD_FWD_EN
      n_checks++;
      if (st !== 1 || int'(stallCount) - c0 !== 1)
         $display("FAIL loaduse_len: stalls=%0d delta=%0d want 1/1", st,
                  int'(stallCount) - c0);
      else n_pass++;
      nop();
      n_checks++;
      if (fwdB !== 2'b10) $display("FAIL loaduse_fwd: fwdB=%b want 10", fwdB);
      else n_pass++;
`else
      n_checks++;
      if (st !== 2 || int'(stallCount) - c0 !== 2 || fwdA !== 2'b00 || fwdB !== 2'b00)
         $display("FAIL raw_len: stalls=%0d delta=%0d fwd=%b%b want 2/2/0000", st,
                  int'(stallCount) - c0, fwdA, fwdB);
      else n_pass++;
`endif
   endtask

   task automatic test_rd_zero();
      apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 2'b01, 1'b0);
      apply(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 2'b00, 1'b0);
      n_checks++;
      if (stallIF !== 1'b0 || ctl !== e_ctl)
         $display("FAIL rd_zero: stallIF=%b ctl=%b want 0 / %b", stallIF, ctl, e_ctl);
      else n_pass++;
      nop();
   endtask

   task automatic test_branch_stall();
      apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 2'b01, 1'b0);
      apply(1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 2'b00, 1'b1);
      n_checks++;
      if (flushIF !== 1'b1 || flushDE !== 1'b1 || stallIF !== 1'b0 || stallDE !== 1'b0 ||
          ctl !== e_ctl || stallCount !== e_cnt)
         $display("FAIL branch_prio: ctl=%b cnt=%0d want ctl=%b cnt=%0d", ctl, stallCount,
                  e_ctl, e_cnt);
      else n_pass++;
      // The flushed consumer wrote x10; a reader of x10 must not see it in ex.
      apply(1'b0, 5'd10, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
      n_checks++;
      if (stallIF !== 1'b0 || ctl !== e_ctl || stallCount !== e_cnt)
         $display("FAIL branch_bubble: ctl=%b cnt=%0d want ctl=%b cnt=%0d", ctl, stallCount,
                  e_ctl, e_cnt);
      else n_pass++;
      nop();
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 24; k++) begin
         apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 2'b01, 1'b0);
         for (int i = 0; i < 4; i++) begin
            apply(1'b0, 5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
            if (stallIF !== 1'b1) break;
         end
      end
      nop();
      n_checks++;
      if (stallCount4 !== 4'd15 || stallCount4 !== e_cnt4 || stallCount !== e_cnt)
         $display("FAIL saturate: cnt4=%0d cnt=%0d want 15 / %0d", stallCount4, stallCount,
                  e_cnt);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         apply($urandom_range(0, 39) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
               $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
         n_checks++;
         if (ctl !== e_ctl || ctl4 !== e_ctl || stallCount !== e_cnt || stallCount4 !== e_cnt4)
            $display("FAIL random_%0d: ctl=%b ctl4=%b cnt=%0d cnt4=%0d want ctl=%b cnt=%0d cnt4=%0d",
                     i, ctl, ctl4, stallCount, stallCount4, e_ctl, e_cnt, e_cnt4);
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1; rs1Addr = '0; rs2Addr = '0; rs1Used = 1'b0; rs2Used = 1'b0;
      rdDe = '0; ruWriteDe = 1'b0; ruDataSrcDe = 2'b00; branchTaken = 1'b0;
      test_reset();
      test_raw();
      test_rd_zero();
      test_branch_stall();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
